inst_mem_responder: RTL

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

---
 rtl/inst_mem_responder_pkg.sv | 26 ++
 rtl/inst_mem_responder_resp_fifo.sv | 73 +++++++
 rtl/inst_mem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/inst_mem_responder_pkg.sv
// Shared constants, control-state encoding and helpers for the
// instruction memory responder.
package inst_mem_responder_pkg;

    localparam int DEF_MEM_WORDS  = 64;
    localparam int DEF_RESP_DEPTH = 2;
    localparam int WORD_IDX_W     = 6;
    localparam int RESP_W         = 33;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_BUSY = 2'd1;
    localparam logic [STATE_W-1:0] ST_FULL = 2'd2;

    // Classify an occupancy value into the control state that represents it
    function automatic logic [STATE_W-1:0] occToState(input int occ, input int depth);
        if (occ <= 0) begin
            return ST_IDLE;
        end else if (occ >= depth) begin
            return ST_FULL;
        end else begin
            return ST_BUSY;
        end
    endfunction

endpackage

// File: rtl/inst_mem_responder_resp_fifo.sv
// In-order response queue: circular buffer with wrapping read/write
// pointers and an explicit entry count.
module resp_fifo
    import inst_mem_responder_pkg::*;
#(
    parameter int WIDTH = RESP_W,
    parameter int DEPTH = DEF_RESP_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           pushData_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Entry storage carries only data, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            store_q[wrPtr_q] <= pushData_i;
        end
    end

    // Next pointers and count; simultaneous push and pop leave the count alone
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push_i) begin
            wrPtr_d = ptrInc(wrPtr_q);
        end
        if (pop_i) begin
            rdPtr_d = ptrInc(rdPtr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign head_o  = store_q[rdPtr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction memory responder: program-loadable word array read through a
// one-cycle capture stage into an in-order response queue.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS  = DEF_MEM_WORDS,
    parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    input  logic                  ld_en,
    input  logic [WORD_IDX_W-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic [31:0]           memArray_q [MEM_WORDS];
    logic                  s1Valid_q, s1Valid_d;
    logic                  s1Err_q, s1Err_d;
    logic [31:0]           s1Data_q, s1Data_d;
    logic [STATE_W-1:0]    state_q, state_d;
    logic [WORD_IDX_W-1:0] wordIdx;
    logic                  addrErr;
    logic                  accept;
    logic                  pop;
    logic                  fifoEmpty;
    logic [CNT_W-1:0]      fifoCount;
    logic [RESP_W-1:0]     fifoHead;
    int                    occNext;

    // Program load port; the array is intentionally outside reset so a loaded
    // program survives rst_n
    always_ff @(posedge clk) begin
        if (ld_en) begin
            memArray_q[ld_addr] <= ld_data;
        end
    end

    // Decode the byte address; the 6-bit word index spans the whole array, so
    // only high bits or a misaligned offset make a request erroneous
    always_comb begin
        wordIdx = req_addr[7:2];
        addrErr = (req_addr[31:8] != '0) || (req_addr[1:0] != 2'b00);
    end

    // Acceptance is decided purely from registered state plus the load strobe
    assign req_ready = (state_q != ST_FULL) && !ld_en;
    assign accept    = req_valid && req_ready;
    assign pop       = resp_valid && resp_ready;

    // Capture stage: array is read at the accept edge, so a same-edge load
    // to the same word is seen as its old value
    always_comb begin
        s1Valid_d = accept;
        s1Err_d   = s1Err_q;
        s1Data_d  = s1Data_q;
        if (accept) begin
            s1Err_d  = addrErr;
            s1Data_d = addrErr ? 32'h0000_0000 : memArray_q[wordIdx];
        end
    end

    // Control state tracks occupancy (queued entries plus the capture stage)
    // as it will be after this edge
    always_comb begin
        occNext = int'(fifoCount) + int'(s1Valid_q) - int'(pop) + int'(s1Valid_d);
        state_d = occToState(occNext, RESP_DEPTH);
    end

    // Capture stage and control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Err_q   <= 1'b0;
            s1Data_q  <= 32'h0000_0000;
            state_q   <= ST_IDLE;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Err_q   <= s1Err_d;
            s1Data_q  <= s1Data_d;
            state_q   <= state_d;
        end
    end

    // The capture stage always drains into the queue on the following edge;
    // occupancy accounting guarantees the queue has room for it
    resp_fifo #(
        .WIDTH(RESP_W),
        .DEPTH(RESP_DEPTH)
    ) u_respFifo (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .push_i     (s1Valid_q),
        .pushData_i ({s1Err_q, s1Data_q}),
        .pop_i      (pop),
        .head_o     (fifoHead),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount)
    );

    // Outputs show the queue head, forced to zero while nothing is queued
    always_comb begin
        resp_valid = !fifoEmpty;
        resp_err   = fifoEmpty ? 1'b0 : fifoHead[32];
        resp_data  = fifoEmpty ? 32'h0000_0000 : fifoHead[31:0];
    end

endmodule
